pipelined_select_adder: RTL and testbench
=========================================

# pipelined_select_adder

Parametrised, pipelined carry-select adder/subtractor with a valid/ready streaming interface. It is the next-generation replacement for the fixed 32-bit combinational select adder in the datapath. Width, select-block size and pipeline depth are configurable, and it adds subtract mode, backpressure and an optional signed-overflow flag. It sits between operand-fetch and writeback stages wherever a registered add/sub with flow control is needed.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of BLOCK.
- BLOCK, 4, bits per carry-select block (ripple-carry pair + mux).
- STAGES, 2, pipeline register stages. Must be ≥1, and (WIDTH/BLOCK) must be a multiple of STAGES.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  adder can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: a+b; 1: a−b.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH+1  result; sum[WIDTH] is the carry-out (for subtract: 1 = no borrow).
- overflow  output  1  signed overflow of sum[WIDTH-1:0].

## Operation
- Subtract is implemented as a + ~b with carry-in 1. Add uses carry-in 0. sub is captured with the operands.
- Operands are split into NB = WIDTH/BLOCK blocks. Each block computes sum/carry for carry-in 0 and 1, then a mux selects using the incoming block carry. Block 0 uses the true carry-in.
- Blocks are grouped into STAGES segments of NB/STAGES consecutive blocks. Segment k is evaluated in pipeline stage k.
- Each stage register holds: valid bit, segment carry-out, completed low-order sum bits, remaining unprocessed high-order operand bits (already inverted for subtract), and the sign bits needed for overflow.
- The final stage register drives sum, overflow and out_valid.
- Overflow is computed as carry-into-MSB XOR carry-out-of-MSB.
- Flow control:
  - Stage k advances (captures from stage k−1, or from the input for k=0) when it is empty or stage k+1 advances.
  - The last stage advances when it is empty or out_ready=1.
  - in_ready = advance condition of stage 0. Transfers occur only when in_valid and in_ready are both 1.
  - Bubbles collapse: an empty stage accepts even while downstream stalls.
- A stage that does not advance holds its contents. Results are never dropped, duplicated or reordered.
- out_valid and sum remain stable while out_valid=1 and out_ready=0.
- Reset (asynchronous, any time):
  - All valid bits → 0, out_valid=0, sum=0, overflow=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - In-flight operations are discarded; no result from before reset ever appears.

## Timing
- Latency is STAGES cycles from the accepting edge to the out_valid edge (no stall).
- Throughput is 1 result/cycle with out_ready held at 1.
- Capacity is STAGES in-flight results. With out_ready=0, exactly STAGES operations are accepted, then in_ready=0.
- in_ready depends combinationally on out_ready (ready chain). No other input-to-output combinational path exists.
- Critical path: one segment of NB/STAGES select blocks (BLOCK-bit ripple + mux chain) plus stage mux.
- Boundary cases:
  - A carry crossing a stage boundary is taken from the registered carry, never recomputed.
  - sub toggling between consecutive operations is correct per operation.
  - If out_ready rises in the same cycle in_valid arrives with a full pipeline, the input is accepted in that cycle.

## Configuration
- PIPELINED_SELECT_ADDER_OVF_EN defined: overflow is computed and pipelined as described above.
- PIPELINED_SELECT_ADDER_OVF_EN undefined: overflow is tied to 0, the sign-bit pipeline registers are absent, and the port list is unchanged.

## Test plan
All scenarios use defaults (WIDTH=32, BLOCK=4, STAGES=2).
- a=0xFFFFFFFF, b=0x00000001, sub=0 → 2 cycles later sum=0x1_00000000, overflow=0 (carry ripples through all blocks and across the stage boundary).
- a=5, b=7, sub=1 → sum=0x0_FFFFFFFE (no carry-out = borrow), overflow=0. Then a=7, b=5, sub=1 → sum=0x1_00000002.
- a=0x7FFFFFFF, b=1, sub=0 → sum=0x0_80000000, overflow=1 with macro, 0 without. Also a=0x80000000, b=1, sub=1 → overflow=1 with macro.
- Stream 4 ops with out_ready=0:
  - First 2 accepted, then in_ready=0 and sum held stable.
  - Release out_ready → remaining 2 accepted, all 4 results emerge in order, none lost.
- Assert rst mid-stream with 2 ops in flight → out_valid=0, sum=0 immediately (async). After release, in_ready=1 and no stale result appears.
- 1000 random back-to-back ops, random sub, out_ready=1 → one result per cycle, each matches the reference a±b (33-bit) exactly.

Source files
------------

// File: rtl/pipelined_select_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// Optional signed-overflow flag is built when PIPELINED_SELECT_ADDER_OVF_EN is defined.
module pipelined_select_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             overflow
);

  localparam int NB   = WIDTH / BLOCK;
  localparam int BPS  = NB / STAGES;
  localparam int SEGW = BLOCK * BPS;
  localparam int LAST = STAGES - 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1. A stage advances when it is empty or the stage after it advances,
  // so in_ready is the head of a combinational ready chain fed by out_ready.

  // Each stage register keeps a single word whose low bits are completed sum
  // bits and whose high bits are still the unprocessed A operand.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q;
  logic [WIDTH-1:0]  acc_q [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];

  logic [STAGES-1:0] vld_in;
  logic [STAGES-1:0] cy_in;
  logic [WIDTH-1:0]  acc_in [STAGES];
  logic [WIDTH-1:0]  opb_in [STAGES];

  logic [STAGES-1:0] cy_d;
  logic [WIDTH-1:0]  acc_d [STAGES];

  logic [STAGES:0]   adv;

  always_comb begin
    adv = '0;
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = ~vld_q[k] | adv[k+1];
    end
  end

  assign in_ready = adv[0];

  genvar k, j;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_src_in
        assign vld_in[0] = in_valid;
        assign cy_in[0]  = sub;
        assign acc_in[0] = a;
        assign opb_in[0] = b ^ {WIDTH{sub}};
      end else begin : g_src_reg
        assign vld_in[k] = vld_q[k-1];
        assign cy_in[k]  = cy_q[k-1];
        assign acc_in[k] = acc_q[k-1];
        assign opb_in[k] = opb_q[k-1];
      end

      logic [BPS:0]      ch;
      logic [SEGW-1:0]   seg;
      logic [WIDTH-1:0]  merged;

      assign ch[0] = cy_in[k];

      for (j = 0; j < BPS; j++) begin : g_blk
        localparam int LO = k * SEGW + j * BLOCK;
        logic [BLOCK:0] r0;
        logic [BLOCK:0] r1;

        assign r0 = {1'b0, acc_in[k][LO +: BLOCK]} + {1'b0, opb_in[k][LO +: BLOCK]};
        assign r1 = {1'b0, acc_in[k][LO +: BLOCK]} + {1'b0, opb_in[k][LO +: BLOCK]}
                    + {{BLOCK{1'b0}}, 1'b1};
        assign seg[j*BLOCK +: BLOCK] = ch[j] ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
        assign ch[j+1]               = ch[j] ? r1[BLOCK]     : r0[BLOCK];
      end

      always_comb begin
        merged = acc_in[k];
        merged[k*SEGW +: SEGW] = seg;
      end

      assign acc_d[k] = merged;
      assign cy_d[k]  = ch[BPS];
    end
  endgenerate

  // Payload only loads on a real transfer, so a stalled or idle output holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        acc_q[s] <= '0;
        opb_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (adv[s]) begin
          vld_q[s] <= vld_in[s];
          if (vld_in[s]) begin
            cy_q[s]  <= cy_d[s];
            acc_q[s] <= acc_d[s];
            opb_q[s] <= opb_in[s];
          end
        end
      end
    end
  end

  assign out_valid = vld_q[LAST];
  assign sum       = {cy_q[LAST], acc_q[LAST]};

`ifdef PIPELINED_SELECT_ADDER_OVF_EN
  // The sign bits travel as the top unprocessed operand bits; the carry into
  // the MSB is recovered as sum_msb ^ a_msb ^ b_msb.
  logic ovf_q;
  logic ovf_d;

  assign ovf_d = acc_d[LAST][WIDTH-1] ^ acc_in[LAST][WIDTH-1]
               ^ opb_in[LAST][WIDTH-1] ^ cy_d[LAST];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv[LAST] && vld_in[LAST]) begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_select_adder.sv
// Scoreboard bench for pipelined_select_adder at default parameters.
module tb_pipelined_select_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [32:0] sum;
  logic        overflow;

  logic [33:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int stall_cnt = 0;

  pipelined_select_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Reference: {overflow, carry, sum} from plain 33-bit arithmetic.
  function automatic logic [33:0] ref_of(input logic [31:0] av, input logic [31:0] bv,
                                         input logic sv);
    logic [32:0] r;
    logic        ov;
    if (sv) r = {1'b0, av} - {1'b0, bv} + 33'h1_0000_0000;
    else    r = {1'b0, av} + {1'b0, bv};
    if (sv) ov = (av[31] != bv[31]) && (r[31] != av[31]);
    else    ov = (av[31] == bv[31]) && (r[31] != av[31]);
`ifndef PIPELINED_SELECT_ADDER_OVF_EN
    ov = 1'b0;
`endif
    return {ov, r};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {31'b0, sum}, 64'h0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("sum", {31'b0, sum}, {31'b0, e[32:0]});
        chk("ovf", {63'b0, overflow}, {63'b0, e[33]});
        n_out++;
      end
    end
  end

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    int waitc;
    waitc = 0;
    a = av;
    b = bv;
    sub = sv;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'h0, 64'h1);
    else exp_q.push_back(ref_of(av, bv, sv));
    stall_cnt += waitc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] held;
    int          k;

    // Reset state.
    #2;
    chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
    chk("rst_sum", {31'b0, sum}, 64'h0);
    chk("rst_ovf", {63'b0, overflow}, 64'h0);
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'b0, in_ready}, 64'h1);
    @(posedge clk);
    #1;

    // Full carry ripple across the stage boundary, plus latency.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("ripple_ref", {30'b0, exp_q[0]}, {30'b0, 34'h1_0000_0000});
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 10);
    chk("latency", k, 2);
    idle(2);

    // Subtract with and without borrow, sub toggling back-to-back.
    send(32'd5, 32'd7, 1'b1);
    send(32'd7, 32'd5, 1'b1);
    send(32'd9, 32'd3, 1'b0);
    send(32'h7FFF_FFFF, 32'h1, 1'b0);
    send(32'h8000_0000, 32'h1, 1'b1);
    send(32'h0, 32'h0, 1'b1);
    idle(4);

    // Backpressure: capacity is two, output holds while stalled.
    out_ready = 1'b0;
    send(32'h1111_1111, 32'h2222_2222, 1'b0);
    send(32'h3333_3333, 32'h0000_0003, 1'b1);
    a = 32'h5555_5555;
    b = 32'h1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("full_in_ready", {63'b0, in_ready}, 64'h0);
    chk("full_out_valid", {63'b0, out_valid}, 64'h1);
    held = sum;
    repeat (3) @(negedge clk);
    chk("stall_sum_stable", {31'b0, sum}, {31'b0, held});
    chk("stall_in_ready", {63'b0, in_ready}, 64'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Same-cycle release: out_ready rises with in_valid on a full pipeline.
    out_ready = 1'b1;
    a = 32'h5555_5555;
    b = 32'h1;
    sub = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {63'b0, in_ready}, 64'h1);
    exp_q.push_back(ref_of(32'h5555_5555, 32'h1, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(32'hDEAD_BEEF, 32'hBEEF_DEAD, 1'b1);
    idle(5);
    chk("stall_drained", exp_q.size(), 0);

    // Asynchronous reset with two operations in flight.
    send(32'h1234_5678, 32'h1, 1'b0);
    send(32'h0F0F_0F0F, 32'h2, 1'b1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_out_valid", {63'b0, out_valid}, 64'h0);
    chk("async_sum", {31'b0, sum}, 64'h0);
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_in_ready", {63'b0, in_ready}, 64'h1);
    idle(6);

    // Random back-to-back stream at full throughput.
    n_out = 0;
    stall_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    chk("no_stall", stall_cnt, 0);
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
    chk("count_out", n_out, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
